// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle for the nibble-serial adder controller.
// The requester drives operands and out_ready; the controller returns status and the result.
interface nibble_serial_adder_ctrl_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         busy;

   modport master (
      output in_valid, op_a, op_b, cin, sub, out_ready,
      input  in_ready, out_valid, result, cout, overflow, busy
   );

   modport slave (
      input  in_valid, op_a, op_b, cin, sub, out_ready,
      output in_ready, out_valid, result, cout, overflow, busy
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built from one shared 4-bit adder, iterated LSB nibble first
// with a registered carry; operands and result move over valid/ready handshakes.
module full_adder_4_bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   nibble_serial_adder_ctrl_if.slave  bus
);
   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  res_q, res_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [IW+1:0] base;
   logic [3:0]    fa_a, fa_b, fa_sum;
   logic          fa_cout;

   assign base = {idx_q, 2'b00};
   assign fa_a = a_q[base +: 4];
   assign fa_b = b_q[base +: 4];

   full_adder_4_bits u_fa (
      .a    (fa_a),
      .b    (fa_b),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               // B is stored pre-inverted so subtraction is A + ~B + 1 on the add path
               a_d     = bus.op_a;
               b_d     = bus.sub ? ~bus.op_b : bus.op_b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               idx_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[base +: 4] = fa_sum;
            carry_d          = fa_cout;
            if (idx_q == LAST) begin
               cout_d  = fa_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (fa_sum[3] != a_q[W-1]);
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == RUN) || (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed vectors and corner sequences on a 4-nibble controller, plus random
// sweeps against a wide reference model for 2, 4 and 8 nibbles.
module tb_nibble_serial_adder_ctrl;
   localparam int unsigned N = 4;
   localparam int unsigned W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rst_sw_n = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();
   nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, waits for the result, samples it, then completes the output handshake.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic su, output logic [W-1:0] r, output logic co,
                         output logic ov, output int lat);
      int t;
      bus.op_a = a;
      bus.op_b = b;
      bus.cin = ci;
      bus.sub = su;
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 50) begin
         step();
         t++;
      end
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         step();
         lat++;
      end
      r = bus.result;
      co = bus.cout;
      ov = bus.overflow;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[11];

   // Random sweeps, one independent controller per width.
   for (genvar g = 0; g < 3; g++) begin : sw
      localparam int unsigned SN = (g == 0) ? 2 : ((g == 1) ? 4 : 8);
      localparam int unsigned SW = 4 * SN;
      logic done_f = 1'b0;

      nibble_serial_adder_ctrl_if #(.NIBBLES(SN)) sif ();
      nibble_serial_adder_ctrl #(.NIBBLES(SN)) u (
         .clk   (clk),
         .rst_n (rst_sw_n),
         .bus   (sif)
      );

      initial begin
         logic [SW-1:0] a, b, exp_r;
         logic [SW:0]   full;
         logic          ci, su, exp_c, exp_o;
         int            t;
         sif.in_valid = 1'b0;
         sif.out_ready = 1'b0;
         sif.op_a = '0;
         sif.op_b = '0;
         sif.cin = 1'b0;
         sif.sub = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         for (int i = 0; i < 1000; i++) begin
            a = SW'($urandom);
            b = SW'($urandom);
            ci = 1'($urandom_range(0, 1));
            su = 1'($urandom_range(0, 1));
            if (su) begin
               full = {1'b0, a} + {1'b0, ~b} + (SW + 1)'(1);
               exp_r = full[SW-1:0];
               exp_o = (a[SW-1] != b[SW-1]) && (exp_r[SW-1] != a[SW-1]);
            end else begin
               full = {1'b0, a} + {1'b0, b} + (SW + 1)'(ci);
               exp_r = full[SW-1:0];
               exp_o = (a[SW-1] == b[SW-1]) && (exp_r[SW-1] != a[SW-1]);
            end
            exp_c = full[SW];
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            sif.op_a = a;
            sif.op_b = b;
            sif.cin = ci;
            sif.sub = su;
            sif.in_valid = 1'b1;
            t = 0;
            while (!sif.in_ready && t < 50) begin
               @(posedge clk);
               #1;
               t++;
            end
            @(posedge clk);
            #1;
            sif.in_valid = 1'b0;
            t = 0;
            while (!sif.out_valid && t < 100) begin
               @(posedge clk);
               #1;
               t++;
            end
            if (!sif.out_valid) begin
               check($sformatf("sweep%0d_timeout", SN), 64'(sif.out_valid), 64'(1));
               break;
            end
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
            check($sformatf("sweep%0d_op%0d", SN, i),
                  64'({sif.cout, sif.overflow, sif.result}), 64'({exp_c, exp_o, exp_r}));
            sif.out_ready = 1'b1;
            @(posedge clk);
            #1;
            sif.out_ready = 1'b0;
         end
         done_f = 1'b1;
      end
   end

   initial begin
      logic [W-1:0] r;
      logic         co, ov;
      int           lat, t;

      vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[7]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[9]  = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
      vecs[10] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.cin = 1'b0;
      bus.sub = 1'b0;

      #2;
      rst_n = 1'b0;
      rst_sw_n = 1'b0;
      #1;
      check("reset_state",
            64'({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.overflow, bus.result}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
      repeat (2) step();
      rst_n = 1'b1;
      rst_sw_n = 1'b1;
      step();

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r, co, ov, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
         check($sformatf("vec%0d_result", i), 64'({co, ov, r}),
               64'({vecs[i].co, vecs[i].ov, vecs[i].res}));
         check($sformatf("vec%0d_post_handshake", i),
               64'({bus.in_ready, bus.out_valid, bus.busy}), 64'({1'b1, 1'b0, 1'b0}));
      end

      // Backpressure with a competing request held during RUN and DONE.
      bus.op_a = 16'h1234;
      bus.op_b = 16'h0FFF;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.op_a = 16'h1111;
      bus.op_b = 16'h2222;
      check("bp_run_status", 64'({bus.in_ready, bus.busy, bus.out_valid}),
            64'({1'b0, 1'b1, 1'b0}));
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("bp_latency", 64'(lat), 64'(N));
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("bp_hold%0d", k),
               64'({bus.out_valid, bus.in_ready, bus.cout, bus.overflow, bus.result}),
               64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h2233}));
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("bp_ready_after_transfer", 64'({bus.in_ready, bus.out_valid}), 64'({1'b1, 1'b0}));
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("bp_held_latency", 64'(lat), 64'(N));
      check("bp_held_result", 64'({bus.cout, bus.overflow, bus.result}),
            64'({1'b0, 1'b0, 16'h3333}));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // Reset during the second RUN cycle discards the partial sum.
      bus.op_a = 16'h1234;
      bus.op_b = 16'h1111;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      check("midrun_partial", 64'({bus.busy, bus.result}), 64'({1'b1, 16'h0005}));
      rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs",
            64'({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.overflow, bus.result}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
      step();
      rst_n = 1'b1;
      step();
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, r, co, ov, lat);
      check("post_reset_latency", 64'(lat), 64'(N));
      check("post_reset_result", 64'({co, ov, r}), 64'({1'b0, 1'b0, 16'h0100}));

      t = 0;
      while (!(sw[0].done_f && sw[1].done_f && sw[2].done_f) && t < 60000) begin
         step();
         t++;
      end
      check("sweeps_complete", 64'({sw[0].done_f, sw[1].done_f, sw[2].done_f}), 64'(3'b111));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that performs wide add/subtract operations by reusing a single `full_adder_4_bits` instance, one nibble per clock. It accepts an operand pair over a valid/ready handshake. It iterates the 4-bit adder from least- to most-significant nibble with a registered carry chain, and presents the wide result, carry-out and signed overflow over a second valid/ready handshake. It sits between a requester (register file or command decoder) and the shared 4-bit adder datapath.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range is 2..16.
- `clk` input, 1: sole clock. All state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset. Reset is asserted immediately and released synchronously by the user.
- `in_valid` input, 1: operand request valid.
- `in_ready` output, 1: controller can accept a request. High only in IDLE.
- `op_a` input, W: operand A, unsigned/two's complement.
- `op_b` input, W: operand B.
- `cin` input, 1: carry-in for add. Ignored when `sub`=1.
- `sub` input, 1: 0 computes A+B+cin; 1 computes A−B (B inverted, carry-in forced 1).
- `out_valid` output, 1: result valid. High only in DONE.
- `out_ready` input, 1: consumer accepts the result.
- `result` output, W: sum/difference.
- `cout` output, 1: carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- `overflow` output, 1: signed two's-complement overflow.
- `busy` output, 1: high in RUN or DONE.

## Operation
- Internal registers:
  - `a_reg`, `b_reg` (W bits). `b_reg` stores B already inverted when `sub`=1.
  - `carry_reg`.
  - `idx` (nibble counter, clog2(NIBBLES) bits).
  - `res_reg` (W bits), `cout_reg`, `ovf_reg`.
- One `full_adder_4_bits` instance:
  - a = `a_reg[4*idx +: 4]`, b = `b_reg[4*idx +: 4]`, cin = `carry_reg`.
- FSM states are IDLE, RUN and DONE.
- IDLE (`in_ready`=1):
  - On `in_valid`: capture `op_a`, `op_b` (inverted if `sub`), `carry_reg` ← (`sub` ? 1 : `cin`), `idx` ← 0, `res_reg` ← 0, then go to RUN.
- RUN (one nibble per cycle):
  - `res_reg[4*idx +: 4]` ← adder sum; `carry_reg` ← adder cout; `idx` ← `idx`+1.
  - When `idx` = NIBBLES−1:
    - `cout_reg` ← adder cout.
    - `ovf_reg` ← (`a_reg[W-1]` == `b_reg[W-1]`) && (sum bit 3 != `a_reg[W-1]`).
    - Go to DONE.
- DONE (`out_valid`=1):
  - `result`, `cout` and `overflow` are held stable.
  - On `out_ready`, go to IDLE. `res_reg` is retained until the next acceptance.
- `in_valid` outside IDLE is ignored. The requester must hold the request until `in_ready`.
- `out_valid` never drops without `out_ready`.
- `result`, `cout` and `overflow` are driven directly from `res_reg`, `cout_reg` and `ovf_reg`.
- `idx` wraps only by reset or leaving RUN. It never exceeds NIBBLES−1.
- Arithmetic is modulo 2^W. There are no width extensions.

## Timing
- Reset values:
  - State IDLE; all registers 0.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `result`=0, `cout`=0, `overflow`=0.
- Latency: a request accepted at edge E0 gives `out_valid`=1 after edge E_NIBBLES. That is NIBBLES cycles later (4 for the default).
- Minimum initiation interval is NIBBLES+2 cycles:
  - NIBBLES cycles of RUN.
  - At least 1 cycle in DONE.
  - 1 cycle in IDLE.
- Simultaneous `out_valid` and `out_ready`: transfer completes at that edge. `in_ready` rises the next cycle. There is no same-cycle re-accept.
- Reset mid-RUN or mid-DONE aborts the operation immediately:
  - All outputs return to their reset values asynchronously.
  - The partial result is discarded.
  - The first request after reset release must compute correctly.
- The adder path is combinational within one cycle: registered operands → adder → registered result.

## Test plan
- Add: 0x1234 + 0x0FFF, `cin`=0 → `result`=0x2233, `cout`=0, `overflow`=0. `out_valid` must be high exactly 4 cycles after acceptance.
- Carry ripple across all nibbles: 0xFFFF + 0x0001, `cin`=0 → 0x0000, `cout`=1, `overflow`=0. Also 0x7FFF + 0x0000, `cin`=1 → 0x8000, `cout`=0, `overflow`=1.
- Subtract:
  - 0x0005 − 0x0007 → 0xFFFE, `cout`=0, `overflow`=0.
  - 0x8000 − 0x0001 → 0x7FFF, `cout`=1, `overflow`=1.
  - `cin` is ignored in subtract mode (toggle it, result unchanged).
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `result`/`cout`/`overflow` stable and `out_valid` stays 1. A new `in_valid` with different operands during RUN/DONE is ignored. After `out_ready` pulses, the held request is accepted and computed correctly.
- Reset mid-RUN: assert `rst_n`=0 during the second RUN cycle → all outputs 0, `in_ready`=1 immediately. After release, 0x00FF + 0x0001 → 0x0100.
- Random sweep: 1000 back-to-back requests with random `op_a`/`op_b`/`cin`/`sub` and random `out_ready` gaps, compared against a W-bit reference model. Repeat with NIBBLES=2 and NIBBLES=8.
